// File: rtl/rx_comma_align_20b.sv
`timescale 1ns/1ps
// Purpose: 7-bit comma aligner for a 20-bit GT receive word. It finds the comma
//          bit offset and runs a HUNT/CHECK/LOCKED sync FSM.
// Latency: 1 clk from rwenb to dout/comma_lo/dout_valid/realign.
// Backpressure: none; a word is consumed every cycle and there is no stall path.
// Ports: clk, rst (async active-low) | rwenb raw word, bit 0 earliest |
//        dout aligned word, dout[9:0] earlier code group, bit 0 = 'a' | dout_valid (LOCKED) |
//        comma_lo comma in dout[6:0] | sync_state 0/1/2 | offset 0..19 | realign offset-change pulse
module rx_comma_align_20b #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] rwenb,
  output logic [19:0] dout,
  output logic        dout_valid,
  output logic        comma_lo,
  output logic [1:0]  sync_state,
  output logic [4:0]  offset,
  output logic        realign
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] prev;
  logic [39:0] w;
  logic [19:0] hit;
  logic        any_hit, cur_hit;
  logic [4:0]  first_k, off_nxt;
  logic [3:0]  good_cnt, good_nxt, good_inc;
  logic [3:0]  miss_cnt, miss_nxt, miss_inc;

  // w[0] is the oldest bit: previous word in the low half.
  assign w = {rwenb, prev};

  // Comma at k when bits a..g (w[k]..w[k+6]) read 0011111 or 1100000.
  always_comb begin
    hit = '0;
    for (int k = 0; k < 20; k++) begin
      hit[k] = (w[k +: 7] == 7'b1111100) || (w[k +: 7] == 7'b0000011);
    end
  end

  // Lowest matching candidate wins; scanning downwards lets the lowest overwrite.
  always_comb begin
    first_k = '0;
    for (int k = 19; k >= 0; k--) begin
      if (hit[k]) first_k = 5'(k);
    end
  end

  assign any_hit = |hit;
  assign cur_hit = hit[offset];

  // Counters saturate at 15 so an oversized run can never wrap back below the threshold.
  assign good_inc = (good_cnt == 4'hF) ? 4'hF : good_cnt + 4'd1;
  assign miss_inc = (miss_cnt == 4'hF) ? 4'hF : miss_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    off_nxt   = offset;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    case (state)
      HUNT: begin
        if (any_hit) begin
          off_nxt   = first_k;
          good_nxt  = 4'd1;
          miss_nxt  = '0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (cur_hit) begin
          good_nxt = good_inc;
          if (good_inc >= 4'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            miss_nxt  = '0;
          end
        end else if (any_hit) begin
          // Only foreign commas: restart qualification at the new position.
          off_nxt  = first_k;
          good_nxt = 4'd1;
        end
      end
      LOCKED: begin
        // A comma at our own offset wins even if other offsets also match.
        if (cur_hit) begin
          miss_nxt = '0;
        end else if (any_hit) begin
          miss_nxt = miss_inc;
          if (miss_inc >= 4'(LOSS_CNT)) begin
            // Offset is held; HUNT re-acquires it from the next comma.
            state_nxt = HUNT;
            good_nxt  = '0;
            miss_nxt  = '0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      prev       <= '0;
      offset     <= '0;
      good_cnt   <= '0;
      miss_cnt   <= '0;
      dout       <= '0;
      comma_lo   <= 1'b0;
      dout_valid <= 1'b0;
      realign    <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= rwenb;
      offset     <= off_nxt;
      good_cnt   <= good_nxt;
      miss_cnt   <= miss_nxt;
      // Output uses the post-update offset so a realign takes effect on the same word.
      dout       <= w[{1'b0, off_nxt} +: 20];
      comma_lo   <= hit[off_nxt];
      dout_valid <= (state_nxt == LOCKED);
      realign    <= (off_nxt != offset);
    end
  end

  assign sync_state = state;

endmodule

// File: doc/rx_comma_align_20b.md
RX_COMMA_ALIGN_20B -- requirements
Module: rx_comma_align_20b

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: consecutive commas at the same offset needed to reach LOCKED.
REQ-002 SHALL have parameter LOSS_CNT, default 4: commas at a foreign offset, with no good comma between them, that drop LOCKED.
REQ-003 SHALL have port clk, input, 1: single clock (GT rxusrclk2 domain).
REQ-004 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port rwenb, input, 20: raw GT word. rwenb[0] is the earliest received bit; valid every cycle.
REQ-006 SHALL have port dout, output, 20: aligned word of two code groups. dout[9:0] is the earlier code group, with bit 0 = bit 'a'.
REQ-007 SHALL have port dout_valid, output, 1: dout is aligned (state LOCKED).
REQ-008 SHALL have port comma_lo, output, 1: dout[6:0] holds a comma (either polarity).
REQ-009 SHALL have port sync_state, output, 2: 0=HUNT, 1=CHECK, 2=LOCKED.
REQ-010 SHALL have port offset, output, 5: current bit offset, 0..19.
REQ-011 SHALL have port realign, output, 1: one-cycle pulse when offset changes.

Function
REQ-012 SHALL form a 40-bit window w = {rwenb, prev}, where prev is the rwenb of the previous cycle; w[0] is the oldest bit.
REQ-013 SHALL define a comma at candidate k (0..19) as w[k+6:k] equal to 7'b1111100 or 7'b0000011, i.e. a..g = 0011111 or 1100000.
REQ-014 SHALL pick the lowest k when more than one candidate matches in a cycle (priority encoder).
REQ-015 SHALL register dout <= w[off_nxt+19 : off_nxt], where off_nxt is the offset value after this cycle's update; latency is 1 clk.
REQ-016 SHALL register comma_lo as the comma test at off_nxt; it SHALL be coincident with dout.
REQ-017 SHALL, in HUNT on any comma at k: set offset <= k, good count <= 1, go to CHECK, and pulse realign if k differs from the old offset.
REQ-018 SHALL, in CHECK on a comma at the current offset: increment the good count, and go to LOCKED when it reaches LOCK_CNT.
REQ-019 SHALL, in CHECK on a comma at a different offset only: restart at the new k, with count 1 and a realign pulse, staying in CHECK.
REQ-020 SHALL, in CHECK or LOCKED, leave state and counters unchanged in cycles with no comma.
REQ-021 SHALL, in LOCKED, clear the miss count on a comma at the current offset.
REQ-022 SHALL, in LOCKED, increment the miss count on a comma seen only at other offsets; at LOSS_CNT it SHALL go to HUNT with offset held.
REQ-023 SHALL count a comma at the current offset as good, even if other offsets also match in the same cycle.
REQ-024 SHALL size the counters for LOCK_CNT and LOSS_CNT up to 15 and saturate them; they SHALL never wrap.
REQ-025 SHALL assert dout_valid only in LOCKED, updated on the same edge as the state.
REQ-026 SHALL keep realign low in every cycle where offset is unchanged.

Reset
REQ-027 SHALL, on rst low, immediately drive: state HUNT, offset 0, prev 0, dout 0, comma_lo 0, dout_valid 0, realign 0, counters 0.
REQ-028 SHALL resume operation on the first clk edge after rst deasserts; the first window uses prev = 0.
REQ-029 SHALL, on reset assertion in mid-lock, drop dout_valid asynchronously, with no extra cycle.

Verification
REQ-030 Comma at offset 0, repeated every 2nd word (K28.5/D16.2 stream) -> dout[9:0]=K28.5 (0011111010 or its RD+ form) every other cycle; LOCKED and dout_valid=1 on the 3rd comma; realign never pulses.
REQ-031 Same stream delayed by 7 bits -> offset=7; realign pulses once on the first comma; dout matches the undelayed stream one cycle later; LOCKED on the 3rd comma.
REQ-032 Locked at offset 7, then 4 commas at offset 12 with no comma at offset 7 -> state goes to HUNT on the 4th; the 5th comma sets offset=12 (realign) and relocks after 3.
REQ-033 Locked, then 3 foreign commas, 1 good, then 3 foreign -> stays LOCKED throughout; dout_valid never drops.
REQ-034 Stream with no comma patterns (all D21.5 = 1010101010) from reset -> stays in HUNT; dout_valid=0; offset=0.
REQ-035 rst pulsed low for 1 ns mid-LOCKED, between edges -> all outputs 0 immediately; relock after 3 commas once reset is released.
